// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and
// loads the IF/ID register; handles stalls, EX redirects and EBREAK halt.
module if_fetch_stage #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [31:0]     NOP_INSN    = 32'h0000_0013,
    parameter logic [31:0]     EBREAK_INSN = 32'h0010_0073,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             if_id_valid,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instruction,
    output logic             halted,
    output logic [CNT_W-1:0] squash_count
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } if_id_t;

    localparam if_id_t BUBBLE = '{
        valid: 1'b0,
        pc:    '0,
        insn:  NOP_INSN
    };

    state_t           state_q;
    logic [XLEN-1:0]  pc_q;
    if_id_t           if_id_q;
    logic [CNT_W-1:0] squash_q;

    logic [XLEN-1:0]  pc_seq;
    logic [XLEN-1:0]  redir_pc;
    logic [CNT_W:0]   squash_inc;
    logic [CNT_W:0]   squash_sum;
    logic [CNT_W-1:0] squash_sat;
    logic             is_ebreak;

    // Next-PC candidates and the saturating squash increment.
    always_comb begin
        pc_seq     = pc_q + XLEN'(4);
        redir_pc   = {redirect_target[XLEN-1:2], 2'b00};
        squash_inc = if_id_q.valid ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
        squash_sum = {1'b0, squash_q} + squash_inc;
        squash_sat = squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
        is_ebreak  = (imem_rdata == EBREAK_INSN);
    end

    // Fetch FSM: reset > redirect > stall > halted > normal fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            if_id_q  <= BUBBLE;
            squash_q <= '0;
        end else if (redirect_valid) begin
            state_q  <= ST_RUN;
            pc_q     <= redir_pc;
            if_id_q  <= BUBBLE;
            squash_q <= squash_sat;
        end else if (!stall) begin
            unique case (state_q)
                ST_HALTED: begin
                    if_id_q <= BUBBLE;
                end
                default: begin
                    pc_q          <= pc_seq;
                    if_id_q.valid <= 1'b1;
                    if_id_q.pc    <= pc_q;
                    if_id_q.insn  <= imem_rdata;
                    if (is_ebreak) begin
                        state_q <= ST_HALTED;
                    end
                end
            endcase
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        imem_addr         = pc_q;
        if_id_valid       = if_id_q.valid;
        if_id_pc          = if_id_q.pc;
        if_id_instruction = if_id_q.insn;
        halted            = (state_q == ST_HALTED);
        squash_count      = squash_q;
    end

endmodule
